// File: rtl/mem_writeback_if.sv
// Issue and data-memory bus for the mem_writeback stage.
// master = issuing control unit / memory environment, slave = mem_writeback.
interface mem_writeback_if;
  // instruction issue
  logic        valid_in;
  logic        ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd_addr;
  logic [31:0] alu_result;
  logic [31:0] rs2_data;
  // data memory
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  // register file write port and completion
  logic        rd_we;
  logic [4:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic        done;
  logic        err;

  modport master (
    output valid_in, opcode, funct3, rd_addr, alu_result, rs2_data,
    output mem_ack, mem_rdata,
    input  ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  rd_we, rd_waddr, rd_wdata, done, err
  );

  modport slave (
    input  valid_in, opcode, funct3, rd_addr, alu_result, rs2_data,
    input  mem_ack, mem_rdata,
    output ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output rd_we, rd_waddr, rd_wdata, done, err
  );
endinterface

// File: rtl/mem_writeback.sv
// Memory / writeback stage: completes OP, LOAD and STORE instructions.
// OP results go straight to the register file; LOAD/STORE run one req/ack
// memory transaction with byte-lane steering, load extension and a timeout.
// All outputs are registered from the next-state decode.
module mem_writeback #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  mem_writeback_if.slave bus
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  // counter value seen on the last MEM edge before the timeout fires
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_WB   = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (op == OPC_LOAD) begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
        default:                                ok = 1'b0;
      endcase
    end else if (op == OPC_STORE) begin
      case (f3)
        3'b000, 3'b001, 3'b010: ok = 1'b1;
        default:                ok = 1'b0;
      endcase
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  // funct3[1:0] encodes the access size for both loads and stores
  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    case (f3[1:0])
      2'b01:   ok = (a[0] == 1'b0);
      2'b10:   ok = (a == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << a;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'b00:   b = d[7:0];
      2'b01:   b = d[15:8];
      2'b10:   b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = d;
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [6:0]  op_q, op_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rs2_q, rs2_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        rd_we_q, rd_we_d;
  logic [4:0]  rd_waddr_q, rd_waddr_d;
  logic [31:0] rd_wdata_q, rd_wdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // operands the memory lanes are built from: live inputs at issue, captured ones after
  logic [6:0]  sel_op;
  logic [2:0]  sel_f3;
  logic [31:0] sel_addr;
  logic [31:0] sel_rs2;
  logic        sel_store;

  // next-state, capture and registered-output decode
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    f3_d        = f3_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    rs2_d       = rs2_q;
    cnt_d       = cnt_q;
    ready_d     = 1'b0;
    rd_we_d     = 1'b0;
    rd_waddr_d  = 5'd0;
    rd_wdata_d  = 32'd0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = 32'd0;
    mem_be_d    = 4'd0;
    mem_wdata_d = 32'd0;

    if (state_q == S_IDLE) begin
      sel_op   = bus.opcode;
      sel_f3   = bus.funct3;
      sel_addr = bus.alu_result;
      sel_rs2  = bus.rs2_data;
    end else begin
      sel_op   = op_q;
      sel_f3   = f3_q;
      sel_addr = addr_q;
      sel_rs2  = rs2_q;
    end
    sel_store = (sel_op == OPC_STORE);

    case (state_q)
      S_IDLE: begin
        if (bus.valid_in) begin
          op_d   = bus.opcode;
          f3_d   = bus.funct3;
          rd_d   = bus.rd_addr;
          addr_d = bus.alu_result;
          rs2_d  = bus.rs2_data;
          cnt_d  = 8'd0;
          if (bus.opcode == OPC_OP) begin
            state_d    = S_WB;
            done_d     = 1'b1;
            rd_we_d    = (bus.rd_addr != 5'd0);
            rd_waddr_d = bus.rd_addr;
            rd_wdata_d = bus.alu_result;
          end else if (bus.opcode == OPC_LOAD || bus.opcode == OPC_STORE) begin
            if (is_legal(bus.opcode, bus.funct3) &&
                is_aligned(bus.funct3, bus.alu_result[1:0])) begin
              state_d = S_MEM;
            end else begin
              state_d = S_ERR;
              err_d   = 1'b1;
              done_d  = 1'b1;
            end
          end else begin
            // unknown opcode completes without a register write
            state_d    = S_WB;
            done_d     = 1'b1;
            rd_waddr_d = bus.rd_addr;
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      S_MEM: begin
        // an ack on the final timeout edge still completes normally
        if (bus.mem_ack) begin
          state_d    = S_WB;
          done_d     = 1'b1;
          rd_waddr_d = rd_q;
          if (op_q == OPC_LOAD) begin
            rd_we_d    = (rd_q != 5'd0);
            rd_wdata_d = load_fmt(f3_q, addr_q[1:0], bus.mem_rdata);
          end else begin
            rd_we_d    = 1'b0;
            rd_wdata_d = 32'd0;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB, S_ERR: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase

    // memory bus is driven only while the next state is MEM, so it is stable throughout
    if (state_d == S_MEM) begin
      mem_req_d   = 1'b1;
      mem_we_d    = sel_store;
      mem_addr_d  = {sel_addr[31:2], 2'b00};
      mem_be_d    = sel_store ? store_be(sel_f3, sel_addr[1:0]) : 4'b1111;
      mem_wdata_d = sel_store ? store_wdata(sel_f3, sel_rs2) : 32'd0;
    end else begin
      mem_req_d   = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = 32'd0;
      mem_be_d    = 4'd0;
      mem_wdata_d = 32'd0;
    end
  end

  // FSM state, capture registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= 7'd0;
      f3_q        <= 3'd0;
      rd_q        <= 5'd0;
      addr_q      <= 32'd0;
      rs2_q       <= 32'd0;
      cnt_q       <= 8'd0;
      ready_q     <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      rd_we_q     <= 1'b0;
      rd_waddr_q  <= 5'd0;
      rd_wdata_q  <= 32'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      f3_q        <= f3_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      rs2_q       <= rs2_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rd_we_q     <= rd_we_d;
      rd_waddr_q  <= rd_waddr_d;
      rd_wdata_q  <= rd_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rd_we     = rd_we_q;
  assign bus.rd_waddr  = rd_waddr_q;
  assign bus.rd_wdata  = rd_wdata_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_writeback.sv
// Self-checking bench for mem_writeback: directed cases plus randomized
// loads, stores and OPs checked against an arithmetic reference model.
module tb_mem_writeback;

  localparam int         TO     = 16;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  mem_writeback_if bus();

  mem_writeback #(.MEM_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    longint w;
    longint v;
    int     off;
    w   = longint'(rdata);
    off = int'(addr % 32'd4);
    case (f3)
      3'b000: begin v = (w >> (8 * off)) % 256;   if (v >= 128)   v = v - 256;   end
      3'b001: begin v = (w >> (8 * off)) % 65536; if (v >= 32768) v = v - 65536; end
      3'b100: v = (w >> (8 * off)) % 256;
      3'b101: v = (w >> (8 * off)) % 65536;
      default: v = w;
    endcase
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
    int b;
    case (f3)
      3'b000:  b = 1 << int'(addr % 32'd4);
      3'b001:  b = 3 << int'(addr % 32'd4);
      default: b = 15;
    endcase
    return b[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (f3)
      3'b000:  return (rs2 % 32'd256) * 32'h01010101;
      3'b001:  return (rs2 % 32'd65536) * 32'h00010001;
      default: return rs2;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_quiet();
    bus.valid_in   = 1'b0;
    bus.opcode     = 7'd0;
    bus.funct3     = 3'd0;
    bus.rd_addr    = 5'd0;
    bus.alu_result = 32'd0;
    bus.rs2_data   = 32'd0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 32'd0;
  endtask

  // wait (bounded) until the block is idle; called #1 after an edge
  task automatic to_idle();
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    n_tests++;
    if (bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL to_idle: ready=%b required 1 within 40 cycles", bus.ready);
    end
  endtask

  // present one instruction in an IDLE cycle; returns #1 after the issue edge
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rs2);
    bus.valid_in   = 1'b1;
    bus.opcode     = op;
    bus.funct3     = f3;
    bus.rd_addr    = rd;
    bus.alu_result = alu;
    bus.rs2_data   = rs2;
    @(posedge clk); #1;
    bus.valid_in   = 1'b0;
  endtask

  // spend n MEM cycles, acking on the last one if give_ack; held=0 if the bus moved
  task automatic mem_cycles(input int n, input bit give_ack, output bit held);
    logic [31:0] a0, w0;
    logic [3:0]  b0;
    logic        we0;
    a0 = bus.mem_addr; w0 = bus.mem_wdata; b0 = bus.mem_be; we0 = bus.mem_we;
    held = 1'b1;
    for (int i = 1; i <= n; i++) begin
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== a0 || bus.mem_wdata !== w0 ||
          bus.mem_be !== b0 || bus.mem_we !== we0 || bus.done !== 1'b0)
        held = 1'b0;
      bus.mem_ack = give_ack && (i == n);
      @(posedge clk); #1;
    end
    bus.mem_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    to_idle();
    issue(OPC_OP, 3'd0, 5'd7, 32'hCAFE_0001, 32'd0);
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (bus.ready !== 1'b1 || bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 ||
        bus.rd_we !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready=%b req=%b we=%b rd_we=%b done=%b err=%b required 1,0,0,0,0,0",
               bus.ready, bus.mem_req, bus.mem_we, bus.rd_we, bus.done, bus.err);
    end
    n_tests++;
    if (bus.mem_addr !== 32'd0 || bus.mem_be !== 4'd0 || bus.mem_wdata !== 32'd0 ||
        bus.rd_waddr !== 5'd0 || bus.rd_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h be=%h wdata=%h waddr=%0d rd_wdata=%h required all 0",
               bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.rd_waddr, bus.rd_wdata);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_op();
    to_idle();
    issue(OPC_OP, 3'd0, 5'd5, 32'h0000_1234, 32'd0);
    n_tests++;
    if (bus.rd_we !== 1'b1 || bus.rd_waddr !== 5'd5 || bus.rd_wdata !== 32'h0000_1234 ||
        bus.done !== 1'b1 || bus.ready !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL op_wb: rd_we=%b waddr=%0d wdata=%h done=%b ready=%b err=%b required 1,5,00001234,1,0,0",
               bus.rd_we, bus.rd_waddr, bus.rd_wdata, bus.done, bus.ready, bus.err);
    end
    @(posedge clk); #1;
    n_tests++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.rd_we !== 1'b0) begin
      n_fail++;
      $display("FAIL op_ready: ready=%b done=%b rd_we=%b required 1,0,0", bus.ready, bus.done, bus.rd_we);
    end
  endtask

  // one load: check bus after issue, ack after dly cycles, check writeback against the model
  task automatic run_load(input string name, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] addr, input logic [31:0] rdata, input int dly);
    bit          held;
    logic [31:0] exp_d;
    to_idle();
    bus.mem_rdata = rdata;
    issue(OPC_LD, f3, rd, addr, 32'hDEAD_BEEF);
    n_tests++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== ((addr / 32'd4) * 32'd4) ||
        bus.mem_be !== 4'b1111 || bus.mem_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL %s_bus: req=%b we=%b addr=%h be=%b wdata=%h required 1,0,%h,1111,0",
               name, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata,
               (addr / 32'd4) * 32'd4);
    end
    mem_cycles(dly, 1'b1, held);
    exp_d = ref_load(f3, addr, rdata);
    n_tests++;
    if (!held || bus.done !== 1'b1 || bus.err !== 1'b0 || bus.mem_req !== 1'b0 ||
        bus.rd_we !== (rd != 5'd0) || (rd != 5'd0 && (bus.rd_waddr !== rd || bus.rd_wdata !== exp_d))) begin
      n_fail++;
      $display("FAIL %s_wb: held=%0d done=%b err=%b req=%b rd_we=%b waddr=%0d wdata=%h required 1,1,0,0,%b,%0d,%h",
               name, held, bus.done, bus.err, bus.mem_req, bus.rd_we, bus.rd_waddr, bus.rd_wdata,
               (rd != 5'd0), rd, exp_d);
    end
    bus.mem_rdata = 32'd0;
  endtask

  task automatic test_load();
    logic [2:0]  f3s [5];
    logic [2:0]  f3;
    logic [31:0] a;
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    run_load("lb",  3'b000, 5'd3, 32'h0000_1003, 32'h80FF_0000, 3);
    run_load("lbu", 3'b100, 5'd3, 32'h0000_1003, 32'h80FF_0000, 3);
    run_load("lh",  3'b001, 5'd4, 32'h0000_1002, 32'h80FF_0000, 3);
    for (int i = 0; i < 20; i++) begin
      f3 = f3s[$urandom_range(0, 4)];
      a  = $urandom;
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      run_load("rnd_ld", f3, 5'($urandom_range(0, 31)), a, $urandom, $urandom_range(1, 6));
    end
  endtask

  task automatic run_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rs2, input int dly);
    bit held;
    to_idle();
    issue(OPC_ST, f3, 5'd9, addr, rs2);
    n_tests++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== ((addr / 32'd4) * 32'd4) ||
        bus.mem_be !== ref_be(f3, addr) || bus.mem_wdata !== ref_wdata(f3, rs2)) begin
      n_fail++;
      $display("FAIL %s_bus: req=%b we=%b addr=%h be=%b wdata=%h required 1,1,%h,%b,%h",
               name, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata,
               (addr / 32'd4) * 32'd4, ref_be(f3, addr), ref_wdata(f3, rs2));
    end
    mem_cycles(dly, 1'b1, held);
    n_tests++;
    if (!held || bus.done !== 1'b1 || bus.rd_we !== 1'b0 || bus.err !== 1'b0 || bus.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done: held=%0d done=%b rd_we=%b err=%b req=%b required 1,1,0,0,0",
               name, held, bus.done, bus.rd_we, bus.err, bus.mem_req);
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3;
    logic [31:0] a;
    run_store("sh", 3'b001, 32'h0000_2002, 32'hAAAA_BEEF, 4);
    for (int i = 0; i < 15; i++) begin
      f3 = 3'($urandom_range(0, 2));
      a  = $urandom;
      if (f3 == 3'b001) a[0] = 1'b0;
      if (f3 == 3'b010) a[1:0] = 2'b00;
      run_store("rnd_st", f3, a, $urandom, $urandom_range(1, 6));
    end
  endtask

  // an instruction that must finish in ERR on the very next cycle
  task automatic run_err(input string name, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] addr);
    to_idle();
    issue(op, f3, 5'd6, addr, 32'h1111_2222);
    n_tests++;
    if (bus.err !== 1'b1 || bus.done !== 1'b1 || bus.rd_we !== 1'b0 || bus.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: err=%b done=%b rd_we=%b req=%b required 1,1,0,0",
               name, bus.err, bus.done, bus.rd_we, bus.mem_req);
    end
    @(posedge clk); #1;
    n_tests++;
    if (bus.err !== 1'b0 || bus.done !== 1'b0 || bus.mem_req !== 1'b0 || bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_after: err=%b done=%b req=%b ready=%b required 0,0,0,1",
               name, bus.err, bus.done, bus.mem_req, bus.ready);
    end
  endtask

  task automatic test_errors();
    run_err("lw_misaligned",  OPC_LD, 3'b010, 32'h0000_2001);
    run_err("ld_funct3_011",  OPC_LD, 3'b011, 32'h0000_2000);
    run_err("sh_misaligned",  OPC_ST, 3'b001, 32'h0000_2003);
    run_err("st_funct3_100",  OPC_ST, 3'b100, 32'h0000_2000);
    // OP writing x0 completes without a register write
    to_idle();
    issue(OPC_OP, 3'd0, 5'd0, 32'h5555_5555, 32'd0);
    n_tests++;
    if (bus.done !== 1'b1 || bus.rd_we !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL op_rd0: done=%b rd_we=%b err=%b required 1,0,0", bus.done, bus.rd_we, bus.err);
    end
    // unknown opcode completes without a write or an error
    to_idle();
    issue(7'b0010011, 3'd0, 5'd8, 32'h7777_0000, 32'd0);
    n_tests++;
    if (bus.done !== 1'b1 || bus.rd_we !== 1'b0 || bus.err !== 1'b0 || bus.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL other_opc: done=%b rd_we=%b err=%b req=%b required 1,0,0,0",
               bus.done, bus.rd_we, bus.err, bus.mem_req);
    end
  endtask

  task automatic test_timeout();
    bit held;
    to_idle();
    issue(OPC_LD, 3'b010, 5'd10, 32'h0000_3000, 32'd0);
    mem_cycles(TO, 1'b0, held);
    n_tests++;
    if (!held || bus.err !== 1'b1 || bus.done !== 1'b1 || bus.mem_req !== 1'b0 || bus.rd_we !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: held=%0d err=%b done=%b req=%b rd_we=%b required 1,1,1,0,0",
               held, bus.err, bus.done, bus.mem_req, bus.rd_we);
    end
    to_idle();
    bus.mem_rdata = 32'h1357_9BDF;
    issue(OPC_LD, 3'b010, 5'd10, 32'h0000_3000, 32'd0);
    mem_cycles(TO, 1'b1, held);
    n_tests++;
    if (!held || bus.err !== 1'b0 || bus.done !== 1'b1 || bus.rd_we !== 1'b1 ||
        bus.rd_wdata !== 32'h1357_9BDF) begin
      n_fail++;
      $display("FAIL ack_last_edge: held=%0d err=%b done=%b rd_we=%b wdata=%h required 1,0,1,1,13579bdf",
               held, bus.err, bus.done, bus.rd_we, bus.rd_wdata);
    end
    bus.mem_rdata = 32'd0;
  endtask

  // valid_in held high: OPs complete every second cycle, junk in the WB cycle is ignored
  task automatic test_back_to_back();
    logic [4:0]  rd;
    logic [31:0] v;
    to_idle();
    for (int i = 0; i < 10; i++) begin
      rd = 5'($urandom_range(0, 31));
      v  = $urandom;
      bus.valid_in = 1'b1; bus.opcode = OPC_OP; bus.rd_addr = rd; bus.alu_result = v;
      @(posedge clk); #1;
      n_tests++;
      if (bus.done !== 1'b1 || bus.rd_we !== (rd != 5'd0) ||
          (rd != 5'd0 && (bus.rd_waddr !== rd || bus.rd_wdata !== v))) begin
        n_fail++;
        $display("FAIL b2b_wb: done=%b rd_we=%b waddr=%0d wdata=%h required 1,%b,%0d,%h",
                 bus.done, bus.rd_we, bus.rd_waddr, bus.rd_wdata, (rd != 5'd0), rd, v);
      end
      bus.opcode = OPC_LD; bus.funct3 = 3'b010; bus.rd_addr = 5'd31; bus.alu_result = $urandom;
      bus.mem_ack = 1'b1;
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      n_tests++;
      if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.rd_we !== 1'b0 || bus.mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_idle: ready=%b done=%b rd_we=%b req=%b required 1,0,0,0",
                 bus.ready, bus.done, bus.rd_we, bus.mem_req);
      end
    end
    drive_quiet();
  endtask

  task automatic test_reset_mid_mem();
    bit held;
    to_idle();
    issue(OPC_LD, 3'b010, 5'd12, 32'h0000_0040, 32'd0);
    mem_cycles(2, 1'b0, held);
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (!held || bus.mem_req !== 1'b0 || bus.rd_we !== 1'b0 || bus.done !== 1'b0 || bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_mem: held=%0d req=%b rd_we=%b done=%b ready=%b required 1,0,0,0,1",
               held, bus.mem_req, bus.rd_we, bus.done, bus.ready);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (bus.done !== 1'b0 || bus.rd_we !== 1'b0 || bus.mem_req !== 1'b0 || bus.ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_after: cycle=%0d done=%b rd_we=%b req=%b ready=%b required 0,0,0,1",
                 i, bus.done, bus.rd_we, bus.mem_req, bus.ready);
      end
    end
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    drive_quiet();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_op();
    test_load();
    test_store();
    test_errors();
    test_timeout();
    test_back_to_back();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
